// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch resolution. It holds the processor status flags,
// evaluates condition codes, issues a one-cycle PC redirect, raises a
// fixed-length flush after each taken branch, and owns the return-address
// stack.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flag_we, alu_flags        flag register load ({V,C,Z,S})
//   br_valid, br_cond         branch request and condition code
//   pc, target                branch address and precomputed target
//   br_ready                  1 when no flush is in progress
//   redirect, redirect_pc     one-cycle fetch redirect
//   flush                     squash younger instructions
//   illegal_cond              one-cycle pulse on an accepted reserved code
//   ras_empty, ras_full       return-address stack occupancy
//   ras_err                   sticky stack overflow/underflow
module branch_resolve_unit #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flag_we,
  input  logic [3:0]      alu_flags,
  input  logic            br_valid,
  input  logic [3:0]      br_cond,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  output logic            br_ready,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal_cond,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_BLTZ = 4'b0001;
  localparam logic [3:0] C_BZ   = 4'b0010;
  localparam logic [3:0] C_BNZ  = 4'b0011;
  localparam logic [3:0] C_BCY  = 4'b0100;
  localparam logic [3:0] C_BNCY = 4'b0101;
  localparam logic [3:0] C_BGEZ = 4'b0110;
  localparam logic [3:0] C_BGTZ = 4'b0111;
  localparam logic [3:0] C_BLEZ = 4'b1000;
  localparam logic [3:0] C_BOV  = 4'b1001;
  localparam logic [3:0] C_BNOV = 4'b1010;
  localparam logic [3:0] C_JMP  = 4'b1011;
  localparam logic [3:0] C_CALL = 4'b1100;
  localparam logic [3:0] C_RET  = 4'b1101;

  // State registers
  logic [3:0]      flags_q, flags_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic            ras_err_q, ras_err_d;

  // Combinational decode
  logic            accept_c;
  logic [3:0]      eval_flags_c;
  logic            v_c, c_c, z_c, s_c;
  logic            taken_c;
  logic            illegal_c;
  logic            push_c;
  logic            pop_c;
  logic            underflow_c;
  logic            is_full_c;
  logic            is_empty_c;
  logic [PTR_W-1:0] top_idx_c;

  assign is_full_c  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign is_empty_c = (ras_cnt_q == '0);
  assign top_idx_c  = ras_ptr_q - PTR_W'(1);

  assign br_ready     = (flush_cnt_q == '0);
  assign flush        = (flush_cnt_q != '0);
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign illegal_cond = illegal_q;
  assign ras_empty    = is_empty_c;
  assign ras_full     = is_full_c;
  assign ras_err      = ras_err_q;

  assign accept_c = br_valid & br_ready;
  // Flags written in the same cycle as an accepted branch are forwarded.
  assign eval_flags_c = (flag_we & accept_c) ? alu_flags : flags_q;
  assign {v_c, c_c, z_c, s_c} = eval_flags_c;

  // Condition evaluation and stack request decode
  always_comb begin
    taken_c     = 1'b0;
    illegal_c   = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
    unique case (br_cond)
      C_NONE: taken_c = 1'b0;
      C_BLTZ: taken_c = s_c;
      C_BZ:   taken_c = z_c;
      C_BNZ:  taken_c = ~z_c;
      C_BCY:  taken_c = c_c;
      C_BNCY: taken_c = ~c_c;
      C_BGEZ: taken_c = ~s_c;
      C_BGTZ: taken_c = ~s_c & ~z_c;
      C_BLEZ: taken_c = s_c | z_c;
      C_BOV:  taken_c = v_c;
      C_BNOV: taken_c = ~v_c;
      C_JMP:  taken_c = 1'b1;
      C_CALL: begin
        taken_c = 1'b1;
        push_c  = 1'b1;
      end
      C_RET: begin
        pop_c       = ~is_empty_c;
        taken_c     = ~is_empty_c;
        underflow_c = is_empty_c;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    flags_d       = flag_we ? alu_flags : flags_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    illegal_d     = 1'b0;
    flush_cnt_d   = (flush_cnt_q != '0) ? flush_cnt_q - FL_W'(1) : flush_cnt_q;
    ras_ptr_d     = ras_ptr_q;
    ras_cnt_d     = ras_cnt_q;
    ras_err_d     = ras_err_q;

    if (accept_c) begin
      illegal_d = illegal_c;
      if (taken_c) begin
        redirect_d    = 1'b1;
        redirect_pc_d = pop_c ? ras_q[top_idx_c] : target;
        flush_cnt_d   = FL_W'(FLUSH_CYCLES);
      end
      if (push_c) begin
        // When full, the write slot holds the oldest entry, so it is overwritten.
        ras_ptr_d = ras_ptr_q + PTR_W'(1);
        if (is_full_c) begin
          ras_err_d = 1'b1;
        end else begin
          ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end
      end
      if (pop_c) begin
        ras_ptr_d = top_idx_c;
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
      if (underflow_c) begin
        ras_err_d = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      flush_cnt_q   <= '0;
      ras_ptr_q     <= '0;
      ras_cnt_q     <= '0;
      ras_err_q     <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      flags_q       <= flags_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      flush_cnt_q   <= flush_cnt_d;
      ras_ptr_q     <= ras_ptr_d;
      ras_cnt_q     <= ras_cnt_d;
      ras_err_q     <= ras_err_d;
      if (accept_c && push_c) begin
        ras_q[ras_ptr_q] <= pc + PC_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_branch_resolve_unit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned RAS   = 4;
  localparam int unsigned FLUSH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flag_we;
  logic [3:0]      alu_flags;
  logic            br_valid;
  logic [3:0]      br_cond;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  logic            br_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            illegal_cond;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.PC_W(PC_W), .RAS_DEPTH(RAS), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .alu_flags(alu_flags),
    .br_valid(br_valid), .br_cond(br_cond), .pc(pc), .target(target),
    .br_ready(br_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .illegal_cond(illegal_cond), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]      m_flags;
  int              m_busy;         // cycles of flush remaining
  logic [31:0]     m_stack[$];     // back = most recent return address
  bit              m_err;
  bit              e_redir;
  bit              e_ill;
  logic [31:0]     e_pc;

  always @(posedge clk or posedge rst) begin
    logic [3:0]  ef;
    bit          acc;
    bit          tk;
    logic [31:0] dst;
    if (rst) begin
      m_flags = 4'b0; m_busy = 0; m_stack.delete(); m_err = 0;
      e_redir = 0; e_ill = 0; e_pc = 32'h0;
    end else begin
      acc = br_valid && (m_busy == 0);
      ef  = (flag_we && acc) ? alu_flags : m_flags;
      e_redir = 0;
      e_ill   = 0;
      if (m_busy > 0) m_busy--;
      if (acc) begin
        tk  = 0;
        dst = target;
        // ef = {V,C,Z,S}
        case (br_cond)
          4'd1:  tk = ef[0];
          4'd2:  tk = ef[1];
          4'd3:  tk = !ef[1];
          4'd4:  tk = ef[2];
          4'd5:  tk = !ef[2];
          4'd6:  tk = !ef[0];
          4'd7:  tk = !ef[0] && !ef[1];
          4'd8:  tk = ef[0] || ef[1];
          4'd9:  tk = ef[3];
          4'd10: tk = !ef[3];
          4'd11: tk = 1;
          4'd12: begin
            tk = 1;
            m_stack.push_back(pc + 32'd4);
            if (m_stack.size() > RAS) begin
              void'(m_stack.pop_front());
              m_err = 1;
            end
          end
          4'd13: begin
            if (m_stack.size() > 0) begin
              dst = m_stack.pop_back();
              tk  = 1;
            end else begin
              m_err = 1;
            end
          end
          4'd14, 4'd15: e_ill = 1;
          default: tk = 0;
        endcase
        if (tk) begin
          e_redir = 1;
          e_pc    = dst;
          m_busy  = FLUSH;
        end
      end
      if (flag_we) m_flags = alu_flags;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    expect_eq("redirect", {31'b0, redirect}, {31'b0, e_redir});
    if (e_redir) expect_eq("redirect_pc", redirect_pc, e_pc);
    expect_eq("illegal_cond", {31'b0, illegal_cond}, {31'b0, e_ill});
    expect_eq("flush", {31'b0, flush}, {31'b0, (m_busy != 0)});
    expect_eq("br_ready", {31'b0, br_ready}, {31'b0, (m_busy == 0)});
    expect_eq("ras_empty", {31'b0, ras_empty}, {31'b0, (m_stack.size() == 0)});
    expect_eq("ras_full", {31'b0, ras_full}, {31'b0, (m_stack.size() == RAS)});
    expect_eq("ras_err", {31'b0, ras_err}, {31'b0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [3:0] c, input logic [31:0] p,
                     input logic [31:0] t, input bit fwe, input logic [3:0] f);
    br_valid = v; br_cond = c; pc = p; target = t; flag_we = fwe; alu_flags = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 32'h0, 32'h0, 0, 4'h0);
  endtask

  logic [31:0] ret_exp [4];
  logic [31:0] rp;

  initial begin
    rst = 1'b1;
    flag_we = 0; alu_flags = 0; br_valid = 0; br_cond = 0; pc = 0; target = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    idle(1);
    expect_eq("rst_redirect", {31'b0, redirect}, 32'd0);
    expect_eq("rst_redirect_pc", redirect_pc, 32'd0);
    expect_eq("rst_flush", {31'b0, flush}, 32'd0);
    expect_eq("rst_br_ready", {31'b0, br_ready}, 32'd1);
    expect_eq("rst_ras_empty", {31'b0, ras_empty}, 32'd1);
    expect_eq("rst_ras_err", {31'b0, ras_err}, 32'd0);

    // Forwarded Z flag with bz, then a branch during flush is ignored
    cyc(1, 4'b0010, 32'h0, 32'h100, 1, 4'b0010);
    expect_eq("fwd_redirect", {31'b0, redirect}, 32'd1);
    expect_eq("fwd_redirect_pc", redirect_pc, 32'h100);
    expect_eq("fwd_flush1", {31'b0, flush}, 32'd1);
    cyc(1, 4'b1011, 32'h0, 32'h300, 0, 4'h0);
    expect_eq("fwd_ignored1", {31'b0, redirect}, 32'd0);
    expect_eq("fwd_flush2", {31'b0, flush}, 32'd1);
    cyc(1, 4'b1011, 32'h0, 32'h300, 0, 4'h0);
    expect_eq("fwd_ignored2", {31'b0, redirect}, 32'd0);
    expect_eq("fwd_flush_done", {31'b0, flush}, 32'd0);
    expect_eq("fwd_ready", {31'b0, br_ready}, 32'd1);

    // Signed conditions; not-taken branches accepted back to back
    cyc(0, 4'd0, 32'h0, 32'h0, 1, 4'b0001);
    cyc(1, 4'b0111, 32'h0, 32'h140, 0, 4'h0);
    expect_eq("bgtz_S_nt", {31'b0, redirect}, 32'd0);
    cyc(1, 4'b0010, 32'h0, 32'h150, 0, 4'h0);
    expect_eq("bz_nt", {31'b0, redirect}, 32'd0);
    expect_eq("nt_ready", {31'b0, br_ready}, 32'd1);
    cyc(1, 4'b1000, 32'h0, 32'h180, 0, 4'h0);
    expect_eq("blez_S_t", {31'b0, redirect}, 32'd1);
    expect_eq("blez_pc", redirect_pc, 32'h180);
    idle(2);
    cyc(0, 4'd0, 32'h0, 32'h0, 1, 4'b0000);
    cyc(1, 4'b0111, 32'h0, 32'h1C0, 0, 4'h0);
    expect_eq("bgtz_0_t", {31'b0, redirect}, 32'd1);
    idle(2);

    // Call / ret
    cyc(1, 4'b1100, 32'h40, 32'h200, 0, 4'h0);
    expect_eq("call_pc", redirect_pc, 32'h200);
    expect_eq("call_nonempty", {31'b0, ras_empty}, 32'd0);
    idle(2);
    cyc(1, 4'b1101, 32'h80, 32'hDEAD, 0, 4'h0);
    expect_eq("ret_pc", redirect_pc, 32'h44);
    expect_eq("ret_empty", {31'b0, ras_empty}, 32'd1);
    idle(2);

    // Overflow then underflow
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 4'b1100, 32'(i * 16), 32'h1000, 0, 4'h0);
      idle(2);
    end
    expect_eq("ovf_full", {31'b0, ras_full}, 32'd1);
    expect_eq("ovf_err", {31'b0, ras_err}, 32'd1);
    ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'b1101, 32'h0, 32'h0, 0, 4'h0);
      expect_eq("ret_redirect", {31'b0, redirect}, 32'd1);
      rp = ret_exp[i];
      expect_eq("ret_seq_pc", redirect_pc, rp);
      idle(2);
    end
    cyc(1, 4'b1101, 32'h0, 32'h0, 0, 4'h0);
    expect_eq("udf_no_redirect", {31'b0, redirect}, 32'd0);
    expect_eq("udf_err", {31'b0, ras_err}, 32'd1);
    expect_eq("udf_ready", {31'b0, br_ready}, 32'd1);

    // Reserved code
    cyc(1, 4'b1110, 32'h0, 32'h600, 0, 4'h0);
    expect_eq("ill_pulse", {31'b0, illegal_cond}, 32'd1);
    expect_eq("ill_no_redirect", {31'b0, redirect}, 32'd0);
    idle(1);
    expect_eq("ill_pulse_end", {31'b0, illegal_cond}, 32'd0);

    // Reset during flush
    cyc(1, 4'b1011, 32'h0, 32'h500, 0, 4'h0);
    expect_eq("pre_rst_flush", {31'b0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    expect_eq("rst_mid_flush", {31'b0, flush}, 32'd0);
    expect_eq("rst_mid_ready", {31'b0, br_ready}, 32'd1);
    expect_eq("rst_mid_redirect", {31'b0, redirect}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rpc, $urandom,
          $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
